// File: rtl/utf_pkg.sv
// Shared constants and the encoder state type for the UTF-16 encoder
// and its code point classifier.
package utf_pkg;

  localparam int          CP_W           = 21;
  localparam logic [20:0] MAX_CODE_POINT = 21'h10FFFF;
  localparam logic [20:0] SUPP_BASE      = 21'h10000;
  localparam logic [20:0] SURR_LO_MIN    = 21'hD800;
  localparam logic [20:0] SURR_HI_MAX    = 21'hDFFF;
  localparam logic [15:0] HI_SURR_BASE   = 16'hD800;
  localparam logic [15:0] LO_SURR_BASE   = 16'hDC00;
  localparam logic [15:0] REPLACEMENT    = 16'hFFFD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    HIGH   = 2'd2,
    LOW    = 2'd3
  } enc_state_t;

endpackage

// File: rtl/utf_cp_classify.sv
// Combinational classifier: flags invalid scalars and precomputes the
// BMP flag and the surrogate pair for supplementary code points.
module utf_cp_classify
  import utf_pkg::*;
(
  input  logic [CP_W-1:0] code_point,
  input  logic            in_error,
  output logic            invalid,
  output logic            is_bmp,
  output logic [15:0]     hi_unit,
  output logic [15:0]     lo_unit
);

  logic        is_surrogate;
  logic [19:0] offset;

  assign is_surrogate = (code_point >= SURR_LO_MIN) && (code_point <= SURR_HI_MAX);
  assign invalid      = in_error || is_surrogate || (code_point > MAX_CODE_POINT);
  assign is_bmp       = (code_point <= 21'h00FFFF);

  // Bit 20 only matters for range checks; valid supplementary offsets fit 20 bits.
  assign offset  = code_point[19:0] - SUPP_BASE[19:0];
  assign hi_unit = HI_SURR_BASE | {6'b0, offset[19:10]};
  assign lo_unit = LO_SURR_BASE | {6'b0, offset[9:0]};

endmodule

// File: rtl/utf16_encoder.sv
// Streams decoded Unicode scalars out as UTF-16 code units, splitting
// supplementary scalars into surrogate pairs and counting invalid input.
module utf16_encoder
  import utf_pkg::*;
#(
  parameter bit REPLACE = 1'b1,
  parameter int ERR_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CP_W-1:0]  code_point,
  input  logic             in_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      unit,
  output logic             out_error,
  output logic [ERR_W-1:0] err_count
);

  enc_state_t  state;
  logic [15:0] low_store;
  logic        invalid;
  logic        is_bmp;
  logic [15:0] hi_unit;
  logic [15:0] lo_unit;
  logic        accept;

  utf_cp_classify u_classify (
    .code_point (code_point),
    .in_error   (in_error),
    .invalid    (invalid),
    .is_bmp     (is_bmp),
    .hi_unit    (hi_unit),
    .lo_unit    (lo_unit)
  );

  // A new scalar may be taken whenever the single pending unit drains this cycle.
  assign in_ready  = (state == IDLE) || (((state == SINGLE) || (state == LOW)) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      unit      <= 16'h0000;
      out_error <= 1'b0;
      low_store <= 16'h0000;
    end else if (accept) begin
      if (invalid) begin
        if (REPLACE) begin
          unit      <= REPLACEMENT;
          out_error <= 1'b1;
          state     <= SINGLE;
        end else begin
          state     <= IDLE;
        end
      end else if (is_bmp) begin
        unit      <= code_point[15:0];
        out_error <= 1'b0;
        state     <= SINGLE;
      end else begin
        unit      <= hi_unit;
        low_store <= lo_unit;
        out_error <= 1'b0;
        state     <= HIGH;
      end
    end else if (out_ready) begin
      if (state == HIGH) begin
        unit  <= low_store;
        state <= LOW;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (accept && invalid && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_utf16_encoder.sv
// Directed bench for utf16_encoder: a replacing instance and a dropping
// instance with a narrow error counter, checked with immediate assertions.
module tb_utf16_encoder;

  logic        clock = 1'b0;
  logic        reset;

  logic        clear_r, in_valid_r, in_error_r, out_ready_r;
  logic [20:0] cp_r;
  logic        in_ready_r, out_valid_r, out_error_r;
  logic [15:0] unit_r;
  logic [15:0] err_r;

  logic        clear_d, in_valid_d, in_error_d, out_ready_d;
  logic [20:0] cp_d;
  logic        in_ready_d, out_valid_d, out_error_d;
  logic [15:0] unit_d;
  logic [1:0]  err_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  utf16_encoder #(.REPLACE(1'b1), .ERR_W(16)) dut_r (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_r),
    .in_valid   (in_valid_r),
    .in_ready   (in_ready_r),
    .code_point (cp_r),
    .in_error   (in_error_r),
    .out_valid  (out_valid_r),
    .out_ready  (out_ready_r),
    .unit       (unit_r),
    .out_error  (out_error_r),
    .err_count  (err_r)
  );

  utf16_encoder #(.REPLACE(1'b0), .ERR_W(2)) dut_d (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_d),
    .in_valid   (in_valid_d),
    .in_ready   (in_ready_d),
    .code_point (cp_d),
    .in_error   (in_error_d),
    .out_valid  (out_valid_d),
    .out_ready  (out_ready_d),
    .unit       (unit_d),
    .out_error  (out_error_d),
    .err_count  (err_d)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expect_r(input string tag, input logic v, input logic [15:0] u, input logic e);
    check({tag, ".valid"}, {31'b0, out_valid_r}, {31'b0, v});
    check({tag, ".unit"},  {16'b0, unit_r},      {16'b0, u});
    check({tag, ".err"},   {31'b0, out_error_r}, {31'b0, e});
  endtask

  initial begin
    reset = 1'b0;
    clear_r = 0; in_valid_r = 0; in_error_r = 0; out_ready_r = 1; cp_r = '0;
    clear_d = 0; in_valid_d = 0; in_error_d = 0; out_ready_d = 1; cp_d = '0;
    #12;
    expect_r("reset", 1'b0, 16'h0000, 1'b0);
    check("reset.err_count", {16'b0, err_r}, 32'd0);
    check("reset.in_ready", {31'b0, in_ready_r}, 32'd1);
    check("reset.d_err_count", {30'b0, err_d}, 32'd0);
    reset = 1'b1;
    tick();

    // Back-to-back BMP scalars
    in_valid_r = 1; cp_r = 21'h000041;
    tick();
    expect_r("bmp1", 1'b1, 16'h0041, 1'b0);
    cp_r = 21'h0020AC;
    check("bmp.in_ready", {31'b0, in_ready_r}, 32'd1);
    tick();
    expect_r("bmp2", 1'b1, 16'h20AC, 1'b0);
    in_valid_r = 0;
    tick();
    expect_r("bmp.drain", 1'b0, 16'h20AC, 1'b0);

    // Supplementary scalar as a surrogate pair
    in_valid_r = 1; cp_r = 21'h01F600;
    tick();
    expect_r("pair.hi", 1'b1, 16'hD83D, 1'b0);
    check("pair.hi.in_ready", {31'b0, in_ready_r}, 32'd0);
    in_valid_r = 0;
    tick();
    expect_r("pair.lo", 1'b1, 16'hDE00, 1'b0);
    tick();
    check("pair.drain", {31'b0, out_valid_r}, 32'd0);

    // Invalid scalars replaced with U+FFFD
    in_valid_r = 1; cp_r = 21'h00D800;
    tick();
    expect_r("inv.surr", 1'b1, 16'hFFFD, 1'b1);
    cp_r = 21'h110000;
    tick();
    expect_r("inv.range", 1'b1, 16'hFFFD, 1'b1);
    cp_r = 21'h000041; in_error_r = 1;
    tick();
    expect_r("inv.flag", 1'b1, 16'hFFFD, 1'b1);
    in_valid_r = 0; in_error_r = 0;
    tick();
    check("inv.drain", {31'b0, out_valid_r}, 32'd0);
    check("inv.err_count", {16'b0, err_r}, 32'd3);

    // Backpressure holds the high surrogate and blocks input
    out_ready_r = 0; in_valid_r = 1; cp_r = 21'h10FFFF;
    tick();
    cp_r = 21'h000041;
    for (int i = 0; i < 3; i++) begin
      expect_r("hold", 1'b1, 16'hDBFF, 1'b0);
      check("hold.in_ready", {31'b0, in_ready_r}, 32'd0);
      tick();
    end
    in_valid_r = 0; out_ready_r = 1;
    expect_r("hold.release", 1'b1, 16'hDBFF, 1'b0);
    tick();
    expect_r("hold.lo", 1'b1, 16'hDFFF, 1'b0);
    tick();
    expect_r("hold.drain", 1'b0, 16'hDFFF, 1'b0);

    // Reset in the middle of a pair discards the stored low surrogate
    in_valid_r = 1; cp_r = 21'h01F600;
    tick();
    expect_r("rst.hi", 1'b1, 16'hD83D, 1'b0);
    in_valid_r = 0;
    reset = 1'b0;
    #1;
    expect_r("rst.async", 1'b0, 16'h0000, 1'b0);
    check("rst.err_count", {16'b0, err_r}, 32'd0);
    tick();
    reset = 1'b1;
    in_valid_r = 1; cp_r = 21'h000041;
    tick();
    expect_r("rst.next", 1'b1, 16'h0041, 1'b0);
    in_valid_r = 0;
    tick();
    expect_r("rst.no_orphan", 1'b0, 16'h0041, 1'b0);

    // Drop mode: invalid beats vanish but are counted
    in_valid_d = 1; cp_d = 21'h00DFFF;
    tick();
    check("drop.none", {31'b0, out_valid_d}, 32'd0);
    check("drop.err1", {30'b0, err_d}, 32'd1);
    cp_d = 21'h000042;
    tick();
    check("drop.valid", {31'b0, out_valid_d}, 32'd1);
    check("drop.unit", {16'b0, unit_d}, 32'h0042);
    check("drop.out_error", {31'b0, out_error_d}, 32'd0);
    check("drop.err_still1", {30'b0, err_d}, 32'd1);
    cp_d = 21'h00D800;
    tick();
    check("drop.drain_idle", {31'b0, out_valid_d}, 32'd0);
    check("drop.err2", {30'b0, err_d}, 32'd2);
    in_valid_d = 0; clear_d = 1;
    tick();
    clear_d = 0;
    check("drop.clear", {30'b0, err_d}, 32'd0);

    // Saturation of the 2-bit counter, then clear beating an increment
    in_valid_d = 1; in_error_d = 1; cp_d = 21'h000041;
    for (int i = 0; i < 4; i++) tick();
    check("sat.value", {30'b0, err_d}, 32'd3);
    check("sat.no_output", {31'b0, out_valid_d}, 32'd0);
    clear_d = 1;
    tick();
    check("sat.clear_prio", {30'b0, err_d}, 32'd0);
    clear_d = 0; in_valid_d = 0; in_error_d = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/utf16_encoder.md
Name: utf16_encoder

Overview:
Downstream consumer of the UTF-8 decoder. It takes decoded Unicode scalar values (21-bit code points) and emits UTF-16 code units through a valid/ready stream. BMP scalars produce one unit; supplementary scalars produce a surrogate pair over two beats. Invalid input is replaced with U+FFFD or dropped, and every error is counted.

Parameters:
REPLACE, 1, 1 = emit U+FFFD for an invalid input; 0 = drop it (count it, emit nothing)
ERR_W, 16, width of the saturating error counter

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous; zeroes err_count next edge
in_valid  input  1  code_point/in_error valid
in_ready  output  1  encoder accepts this cycle
code_point  input  21  scalar from decoder
in_error  input  1  decoder flagged this beat as malformed
out_valid  output  1  unit valid
out_ready  input  1  consumer accepts unit
unit  output  16  UTF-16 code unit
out_error  output  1  qualifies the current unit as a replacement (REPLACE=1)
err_count  output  ERR_W  saturating count of invalid inputs

Behaviour:
- Reset (reset=0, async): state IDLE; out_valid=0; unit=16'h0000; out_error=0; err_count=0; held pair data cleared.
- States:
  - IDLE: no output pending.
  - SINGLE: one unit pending.
  - HIGH: high surrogate pending, low surrogate stored.
  - LOW: low surrogate pending.
- in_ready = (state==IDLE) | ((state==SINGLE | state==LOW) & out_ready). Never ready in HIGH.
- Accept = in_valid & in_ready. Classification of the accepted beat:
  - Invalid: in_error=1, or code_point in 0xD800..0xDFFF, or code_point > 0x10FFFF.
    - REPLACE=1: unit=0xFFFD, out_error=1, next state SINGLE.
    - REPLACE=0: nothing emitted. Next state IDLE, or stays idle if the prior unit just drained.
  - code_point <= 0xFFFF: unit=code_point[15:0], out_error=0, next state SINGLE.
  - 0x10000..0x10FFFF: v = code_point - 0x10000 (20 bits).
    - unit = 0xD800 | v[19:10], next state HIGH.
    - Store 0xDC00 | v[9:0] for the low beat.
- HIGH & out_ready: unit=stored low, next state LOW.
- SINGLE/LOW & out_ready with no accept: state IDLE, out_valid=0.
- Timing and throughput:
  - Latency: accept in cycle N gives out_valid=1 in cycle N+1.
  - BMP stream: 1 scalar per cycle with out_ready held 1.
  - Supplementary stream: 1 scalar per 2 cycles.
- Output stability: while out_valid & !out_ready, unit and out_error are held unchanged and no new input is accepted.
- err_count:
  - Increments by 1 per accepted invalid beat, saturating at all-ones.
  - clear has priority over a same-cycle increment; the result is 0.
- Reset mid-pair (in HIGH or LOW): the pending and stored surrogates are discarded. After release, no orphan low surrogate is emitted.
- unit is don't-care when out_valid=0, but it holds its last value; the bench may check that.

Decomposition:
- Package utf_pkg holds:
  - Constants: CP_W=21, MAX_CODE_POINT=21'h10FFFF, SUPP_BASE=21'h10000, SURR_LO_MIN=21'hD800, SURR_HI_MAX=21'hDFFF, HI_SURR_BASE=16'hD800, LO_SURR_BASE=16'hDC00, REPLACEMENT=16'hFFFD.
  - The encoder state enum.
- One combinational sub-module, utf_cp_classify, maps code_point/in_error to {invalid, is_bmp, hi_unit, lo_unit}. It is reusable by a future UTF-8 encoder.

Test Plan:
- Accept 0x000041, then 0x0020AC, back-to-back, with out_ready=1 -> units 0x0041 then 0x20AC on consecutive cycles, out_error=0, in_ready stays 1.
- Accept 0x01F600 -> 0xD83D then 0xDE00 on consecutive cycles; in_ready=0 during the 0xD83D beat.
- REPLACE=1: accept 0x00D800, 0x110000, and 0x000041 with in_error=1 -> three units 0xFFFD with out_error=1; err_count=3.
- REPLACE=0: accept 0x00DFFF, then 0x000042 -> only 0x0042 emitted; err_count=1. Then assert clear -> err_count=0 next cycle.
- Accept 0x10FFFF with out_ready=0 for 3 cycles -> unit held at 0xDBFF. Raise out_ready -> 0xDBFF, then 0xDFFF. No input accepted meanwhile.
- Accept 0x01F600 and pull reset low during the 0xD83D beat -> out_valid=0 immediately. After release, accept 0x000041 -> first unit 0x0041, no 0xDE00.
